// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer pipeline stage (HEAD + SKID) with fully registered outputs,
// registered in_ready, flush squash and synchronous active-low reset.
`timescale 1ns/1ps

module pipe_stage_buf #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 5,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_st_value,
    input  logic [DEST_W-1:0] in_dest,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_st_value,
    output logic [DEST_W-1:0] out_dest,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] st_value;
        logic [DEST_W-1:0] dest;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        HEAD_HOLD  = 2'd0,
        HEAD_IN    = 2'd1,
        HEAD_SKID  = 2'd2,
        HEAD_CLEAR = 2'd3
    } head_sel_t;

    state_t    state_q, state_d;
    head_sel_t head_sel;
    entry_t    head_q, skid_q, in_entry;
    logic      skid_load, skid_clear;
    logic      in_ready_q, out_valid_q;
    logic      accept, drain;

    assign in_entry = '{pc: in_pc, result: in_result, st_value: in_st_value,
                        dest: in_dest, ctrl: in_ctrl};

    // Handshakes use only registered ready/valid, so no out_ready -> in_ready path exists.
    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    always_comb begin
        state_d    = state_q;
        head_sel   = HEAD_HOLD;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d  = ONE;
                    head_sel = HEAD_IN;
                end
            end
            ONE: begin
                if (accept && !drain) begin
                    state_d   = FULL;
                    skid_load = 1'b1;
                end else if (drain && !accept) begin
                    state_d  = EMPTY;
                    head_sel = HEAD_CLEAR;
                end else if (accept && drain) begin
                    head_sel = HEAD_IN;
                end
            end
            FULL: begin
                if (drain) begin
                    state_d    = ONE;
                    head_sel   = HEAD_SKID;
                    skid_clear = 1'b1;
                end
            end
            default: begin
                state_d    = EMPTY;
                head_sel   = HEAD_CLEAR;
                skid_clear = 1'b1;
            end
        endcase
        // Squash wins over any accept/drain decided above.
        if (flush) begin
            state_d    = EMPTY;
            head_sel   = HEAD_CLEAR;
            skid_load  = 1'b0;
            skid_clear = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
            unique case (head_sel)
                HEAD_IN:    head_q <= in_entry;
                HEAD_SKID:  head_q <= skid_q;
                HEAD_CLEAR: head_q <= '0;
                default:    head_q <= head_q;
            endcase
            if (skid_clear)
                skid_q <= '0;
            else if (skid_load)
                skid_q <= in_entry;
        end
    end

    // HEAD is zeroed whenever the stage empties, so a bubble never carries enables.
    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_pc       = head_q.pc;
    assign out_result   = head_q.result;
    assign out_st_value = head_q.st_value;
    assign out_dest     = head_q.dest;
    assign out_ctrl     = head_q.ctrl;
    assign occupancy    = state_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed and randomized checks for pipe_stage_buf: reset, single entry,
// backpressure, streaming, flush, reset-over-flush and a scoreboarded random run.
`timescale 1ns/1ps

module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_result, in_st_value, out_pc, out_result, out_st_value;
    logic [4:0]  in_dest, out_dest;
    logic [2:0]  in_ctrl, out_ctrl;
    logic [1:0]  occupancy;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [31:0] st_value;
        logic [4:0]  dest;
        logic [2:0]  ctrl;
    } ent_t;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(32), .DEST_W(5), .CTRL_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_result(in_result), .in_st_value(in_st_value),
        .in_dest(in_dest), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_result(out_result), .out_st_value(out_st_value),
        .out_dest(out_dest), .out_ctrl(out_ctrl),
        .occupancy(occupancy)
    );

    // Advance one rising edge; observe and drive 1ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] ctrl);
        in_valid    = v;
        in_pc       = pc;
        in_result   = pc ^ 32'h5A5A_0000;
        in_st_value = pc + 32'd7;
        in_dest     = pc[6:2];
        in_ctrl     = ctrl;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 32'h1234, 3'b111);
        cyc();
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
            out_pc !== 32'd0 || out_result !== 32'd0 || out_ctrl !== 3'd0 || out_dest !== 5'd0) begin
            failures++;
            $display("FAIL reset_state occ=%0d ov=%b ir=%b pc=%h ctrl=%b req occ=0 ov=0 ir=1 pc=0 ctrl=0",
                     occupancy, out_valid, in_ready, out_pc, out_ctrl);
        end
        cyc();
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ignores_accept occ=%0d ov=%b ir=%b req occ=0 ov=0 ir=1",
                     occupancy, out_valid, in_ready);
        end
        drive(1'b0, 32'd0, 3'd0);
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_pc       = 32'h100;
        in_result   = 32'hDEADBEEF;
        in_st_value = 32'hCAFE0001;
        in_dest     = 5'd5;
        in_ctrl     = 3'b100;
        cyc();
        drive(1'b0, 32'd0, 3'd0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_result !== 32'hDEADBEEF ||
            out_st_value !== 32'hCAFE0001 || out_dest !== 5'd5 || out_ctrl !== 3'b100 ||
            occupancy !== 2'd1) begin
            failures++;
            $display("FAIL single_entry ov=%b pc=%h res=%h st=%h dest=%0d ctrl=%b occ=%0d req 1 100 deadbeef cafe0001 5 100 1",
                     out_valid, out_pc, out_result, out_st_value, out_dest, out_ctrl, occupancy);
        end
        cyc();
        checks++;
        if (occupancy !== 2'd0 || out_ctrl !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'd0) begin
            failures++;
            $display("FAIL single_drain occ=%0d ctrl=%b ov=%b pc=%h req occ=0 ctrl=0 ov=0 pc=0",
                     occupancy, out_ctrl, out_valid, out_pc);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'h10, 3'b001);
        cyc();
        drive(1'b1, 32'h14, 3'b010);
        cyc();
        drive(1'b0, 32'd0, 3'd0);
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_pc !== 32'h10 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_full occ=%0d ir=%b pc=%h ov=%b req occ=2 ir=0 pc=10 ov=1",
                     occupancy, in_ready, out_pc, out_valid);
        end
        drive(1'b1, 32'h99, 3'b111);  // must be refused while full
        cyc();
        drive(1'b0, 32'd0, 3'd0);
        checks++;
        if (occupancy !== 2'd2 || out_pc !== 32'h10 || out_ctrl !== 3'b001) begin
            failures++;
            $display("FAIL bp_hold occ=%0d pc=%h ctrl=%b req occ=2 pc=10 ctrl=001",
                     occupancy, out_pc, out_ctrl);
        end
        out_ready = 1'b1;
        cyc();
        checks++;
        if (occupancy !== 2'd1 || out_pc !== 32'h14 || out_ctrl !== 3'b010 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_drain1 occ=%0d pc=%h ctrl=%b ir=%b req occ=1 pc=14 ctrl=010 ir=1",
                     occupancy, out_pc, out_ctrl, in_ready);
        end
        cyc();
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain2 occ=%0d ov=%b req occ=0 ov=0", occupancy, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i * 4), 3'(i));
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_ready idx=%0d ir=%b req 1", i, in_ready);
            end
            cyc();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_ctrl !== 3'(i) || occupancy !== 2'd1) begin
                failures++;
                $display("FAIL stream_out idx=%0d ov=%b pc=%h ctrl=%b occ=%0d req 1 %h %b 1",
                         i, out_valid, out_pc, out_ctrl, occupancy, 32'(i * 4), 3'(i));
            end
        end
        drive(1'b0, 32'd0, 3'd0);
        cyc();
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_end occ=%0d ov=%b req 0 0", occupancy, out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h20, 3'b011);
        cyc();
        drive(1'b1, 32'h24, 3'b011);
        cyc();
        flush = 1'b1;
        drive(1'b1, 32'hBAD, 3'b111);
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'd0, 3'd0);
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 3'd0 || occupancy !== 2'd0 || in_ready !== 1'b1 || out_pc !== 32'd0) begin
            failures++;
            $display("FAIL flush_full ov=%b ctrl=%b occ=%0d ir=%b pc=%h req 0 0 0 1 0",
                     out_valid, out_ctrl, occupancy, in_ready, out_pc);
        end
        // Flush in ONE where the input really is handshaked: it must still be dropped.
        drive(1'b1, 32'h30, 3'b011);
        cyc();
        flush = 1'b1;
        drive(1'b1, 32'hBAD, 3'b111);
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'd0, 3'd0);
        cyc();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_pc !== 32'd0 || out_ctrl !== 3'd0) begin
            failures++;
            $display("FAIL flush_one_discard ov=%b occ=%0d pc=%h ctrl=%b req 0 0 0 0",
                     out_valid, occupancy, out_pc, out_ctrl);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 32'h40, 3'b110);
        cyc();
        drive(1'b1, 32'h44, 3'b110);
        cyc();
        rst = 1'b0;
        flush = 1'b1;
        drive(1'b1, 32'h48, 3'b111);
        out_ready = 1'b1;
        cyc();
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'd0 ||
            out_result !== 32'd0 || out_st_value !== 32'd0 || out_dest !== 5'd0 || out_ctrl !== 3'd0) begin
            failures++;
            $display("FAIL reset_mid occ=%0d ov=%b ir=%b pc=%h ctrl=%b req 0 0 1 0 0",
                     occupancy, out_valid, in_ready, out_pc, out_ctrl);
        end
        rst = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'd0, 3'd0);
        cyc();
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t e;
        logic acc, drn;
        int bad = 0;
        for (int c = 0; c < 10000; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 63) == 0);
            in_pc       = $urandom;
            in_result   = $urandom;
            in_st_value = $urandom;
            in_dest     = 5'($urandom);
            in_ctrl     = 3'($urandom);
            checks++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) ||
                occupancy !== 2'(q.size())) begin
                failures++;
                if (bad++ < 10)
                    $display("FAIL rand_status cyc=%0d ov=%b ir=%b occ=%0d req model_size=%0d",
                             c, out_valid, in_ready, occupancy, q.size());
            end else if (q.size() > 0) begin
                e = q[0];
                checks++;
                if (out_pc !== e.pc || out_result !== e.result || out_st_value !== e.st_value ||
                    out_dest !== e.dest || out_ctrl !== e.ctrl) begin
                    failures++;
                    if (bad++ < 10)
                        $display("FAIL rand_head cyc=%0d pc=%h res=%h ctrl=%b req pc=%h res=%h ctrl=%b",
                                 c, out_pc, out_result, out_ctrl, e.pc, e.result, e.ctrl);
                end
            end else begin
                checks++;
                if (out_ctrl !== 3'd0 || out_pc !== 32'd0) begin
                    failures++;
                    if (bad++ < 10)
                        $display("FAIL rand_bubble cyc=%0d ctrl=%b pc=%h req 0 0", c, out_ctrl, out_pc);
                end
            end
            acc = in_valid && (q.size() < 2);
            drn = out_ready && (q.size() > 0);
            if (flush) begin
                q.delete();
            end else begin
                if (drn) void'(q.pop_front());
                if (acc) q.push_back('{pc: in_pc, result: in_result, st_value: in_st_value,
                                       dest: in_dest, ctrl: in_ctrl});
            end
            cyc();
        end
        flush = 1'b0;
        drive(1'b0, 32'd0, 3'd0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'd0, 3'd0);
        #2;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DATA_W, default 32, width of pc, result and store-value fields.
REQ-002 Parameter DEST_W, default 5, width of destination register index.
REQ-003 Parameter CTRL_W, default 3, width of control-flag vector; bit 0 MEM_R_en, bit 1 MEM_W_en, bit 2 WB_en.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  discard all held entries (branch/exception squash).
REQ-007 in_valid  input  1  upstream entry present.
REQ-008 in_ready  output  1  stage can accept an entry this cycle.
REQ-009 in_pc, in_result, in_st_value  input  DATA_W each  upstream payload.
REQ-010 in_dest  input  DEST_W  upstream destination index.
REQ-011 in_ctrl  input  CTRL_W  upstream control flags.
REQ-012 out_valid  output  1  head entry present.
REQ-013 out_ready  input  1  downstream accepts head entry.
REQ-014 out_pc, out_result, out_st_value, out_dest, out_ctrl  output  widths as inputs  head-entry payload.
REQ-015 occupancy  output  2  entries held (0..2).

Function
REQ-016 Storage: two entries, HEAD (drives outputs) and SKID; FIFO order preserved, no entry duplicated or lost except by flush/reset.
REQ-017 States: EMPTY (occupancy 0), ONE (1), FULL (2); occupancy equals state encoding.
REQ-018 Accept = in_valid & in_ready; drain = out_valid & out_ready.
REQ-019 in_ready driven from a register only: 1 in EMPTY/ONE, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-020 out_valid = 1 in ONE/FULL, 0 in EMPTY; all outputs registered (no combinational in->out path).
REQ-021 EMPTY: accept -> ONE, HEAD loaded with input; else stay.
REQ-022 ONE: accept & !drain -> FULL, SKID loaded; drain & !accept -> EMPTY; accept & drain -> ONE, HEAD loaded with input; neither -> stay.
REQ-023 FULL: drain -> ONE, HEAD loaded from SKID; no accept possible (in_ready=0); else stay.
REQ-024 Latency: accepted entry visible on out_* the cycle after accept when stage was EMPTY, or when ONE with simultaneous drain.
REQ-025 Throughput: one entry per cycle sustained while out_ready held 1.
REQ-026 Outputs hold stable while out_valid=1 and out_ready=0.
REQ-027 out_ctrl forced to all-zero whenever out_valid=0 (bubble never asserts memory/writeback enables); other out_* fields zero when EMPTY.
REQ-028 flush=1: next cycle state EMPTY, both entries cleared to zero, in_ready=1; an input accepted-looking in the flush cycle is discarded; drain in flush cycle still counts as completed downstream.
REQ-029 Stored fields pass bit-exact; no arithmetic performed on payload.

Reset
REQ-030 rst=0 at a rising edge: state EMPTY, occupancy 0, out_valid 0, in_ready 1, all payload outputs and out_ctrl 0.
REQ-031 Reset has priority over flush, accept and drain; rst asserted mid-operation drops all entries.
REQ-032 During rst=0 cycles in_ready is held 1 but accepts are ignored.

Verification
REQ-033 Reset then single entry: in_pc=0x100, in_result=0xDEADBEEF, in_dest=5, in_ctrl=3'b100, out_ready=1 -> next cycle out_valid=1, out_pc=0x100, out_result=0xDEADBEEF, out_dest=5, out_ctrl=3'b100, occupancy 1; following cycle occupancy 0, out_ctrl 0.
REQ-034 Backpressure: out_ready=0, push A (pc 0x10) then B (pc 0x14) -> occupancy 2, in_ready=0, out_pc=0x10 stable; out_ready=1 -> out_pc 0x10 then 0x14, occupancy 2->1->0.
REQ-035 Streaming: 8 consecutive entries pc 0x0..0x1C, out_ready=1 -> outputs in order, one per cycle, in_ready never 0.
REQ-036 Flush when FULL (entries with ctrl 3'b011) -> next cycle out_valid 0, out_ctrl 0, occupancy 0, in_ready 1; input in flush cycle never appears.
REQ-037 rst=0 asserted while FULL with flush=1 and in_valid=1 -> next cycle all outputs per REQ-030.
REQ-038 Random in_valid/out_ready, 10k cycles, scoreboard -> output sequence equals accepted sequence between flushes.
